// File: rtl/segre_mem_arbiter.sv
// Arbitrates the external memory port between I-cache refills and D-cache misses.
// One transaction at a time: optional victim writeback, refill read, one-cycle ready pulse.
module segre_mem_arbiter #(
    parameter int unsigned ADDR_SIZE   = 32,
    parameter int unsigned LANE_SIZE   = 128,
    parameter int unsigned OFFSET_BITS = $clog2(LANE_SIZE / 8)
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,

    input  logic                 ic_miss_i,
    input  logic [ADDR_SIZE-1:0] ic_addr_i,
    output logic                 ic_rdy_o,
    output logic [LANE_SIZE-1:0] ic_data_o,

    input  logic                 dc_miss_i,
    input  logic [ADDR_SIZE-1:0] dc_addr_i,
    input  logic                 dc_writeback_i,
    input  logic [ADDR_SIZE-1:0] dc_wb_addr_i,
    input  logic [LANE_SIZE-1:0] dc_wb_data_i,
    output logic                 dc_rdy_o,
    output logic [LANE_SIZE-1:0] dc_data_o,

    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [LANE_SIZE-1:0] mem_wdata_o,
    input  logic                 mem_ack_i,
    input  logic [LANE_SIZE-1:0] mem_rdata_i,

    output logic                 busy_o
);

    typedef enum logic [1:0] {StIdle, StWb, StRd, StResp} state_e;

    localparam logic [ADDR_SIZE-1:0] AlignMask = {ADDR_SIZE{1'b1}} << OFFSET_BITS;

    state_e state_q, state_d;

    // Granted requester and round-robin history (1 = D-cache).
    logic gnt_dc_q, gnt_dc_d;
    logic last_dc_q, last_dc_d;
    logic grant_ic, grant_dc;

    logic [ADDR_SIZE-1:0] miss_addr_q, miss_addr_d;
    logic [ADDR_SIZE-1:0] wb_addr_q, wb_addr_d;
    logic [LANE_SIZE-1:0] wb_data_q, wb_data_d;
    logic [LANE_SIZE-1:0] ic_data_q, ic_data_d;
    logic [LANE_SIZE-1:0] dc_data_q, dc_data_d;

    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [LANE_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                 ic_rdy_q, ic_rdy_d;
    logic                 dc_rdy_q, dc_rdy_d;
    logic                 busy_q, busy_d;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_dc = dc_miss_i && (!ic_miss_i || !last_dc_q);
        grant_ic = ic_miss_i && !grant_dc;
    end

    always_comb begin
        state_d     = state_q;
        gnt_dc_d    = gnt_dc_q;
        last_dc_d   = last_dc_q;
        miss_addr_d = miss_addr_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        ic_data_d   = ic_data_q;
        dc_data_d   = dc_data_q;

        unique case (state_q)
            StIdle: begin
                if (grant_ic || grant_dc) begin
                    gnt_dc_d    = grant_dc;
                    last_dc_d   = grant_dc;
                    miss_addr_d = (grant_dc ? dc_addr_i : ic_addr_i) & AlignMask;
                    if (grant_dc && dc_writeback_i) begin
                        wb_addr_d = dc_wb_addr_i & AlignMask;
                        wb_data_d = dc_wb_data_i;
                        state_d   = StWb;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StWb: begin
                if (mem_ack_i) begin
                    state_d = StRd;
                end
            end
            StRd: begin
                if (mem_ack_i) begin
                    if (gnt_dc_q) begin
                        dc_data_d = mem_rdata_i;
                    end else begin
                        ic_data_d = mem_rdata_i;
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered, so they are derived from the next state and next latches.
    always_comb begin
        mem_req_d   = (state_d == StWb) || (state_d == StRd);
        mem_we_d    = (state_d == StWb);
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (state_d == StWb) begin
            mem_addr_d  = wb_addr_d;
            mem_wdata_d = wb_data_d;
        end else if (state_d == StRd) begin
            mem_addr_d = miss_addr_d;
        end
        ic_rdy_d = (state_d == StResp) && !gnt_dc_d;
        dc_rdy_d = (state_d == StResp) && gnt_dc_d;
        busy_d   = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            state_q     <= StIdle;
            gnt_dc_q    <= 1'b0;
            last_dc_q   <= 1'b0;
            miss_addr_q <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            ic_data_q   <= '0;
            dc_data_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ic_rdy_q    <= 1'b0;
            dc_rdy_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_dc_q    <= gnt_dc_d;
            last_dc_q   <= last_dc_d;
            miss_addr_q <= miss_addr_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            ic_data_q   <= ic_data_d;
            dc_data_q   <= dc_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ic_rdy_q    <= ic_rdy_d;
            dc_rdy_q    <= dc_rdy_d;
            busy_q      <= busy_d;
        end
    end

    assign ic_rdy_o    = ic_rdy_q;
    assign ic_data_o   = ic_data_q;
    assign dc_rdy_o    = dc_rdy_q;
    assign dc_data_o   = dc_data_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Bench for segre_mem_arbiter: directed vector table, hand-written corner sequences and
// a randomized run against a transaction-level reference model.
module tb_segre_mem_arbiter;

    logic         clk_i = 1'b0;
    logic         rsn_i;
    logic         ic_miss_i;
    logic [31:0]  ic_addr_i;
    logic         ic_rdy_o;
    logic [127:0] ic_data_o;
    logic         dc_miss_i;
    logic [31:0]  dc_addr_i;
    logic         dc_writeback_i;
    logic [31:0]  dc_wb_addr_i;
    logic [127:0] dc_wb_data_i;
    logic         dc_rdy_o;
    logic [127:0] dc_data_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic         mem_ack_i;
    logic [127:0] mem_rdata_i;
    logic         busy_o;

    segre_mem_arbiter dut (
        .clk_i          (clk_i),
        .rsn_i          (rsn_i),
        .ic_miss_i      (ic_miss_i),
        .ic_addr_i      (ic_addr_i),
        .ic_rdy_o       (ic_rdy_o),
        .ic_data_o      (ic_data_o),
        .dc_miss_i      (dc_miss_i),
        .dc_addr_i      (dc_addr_i),
        .dc_writeback_i (dc_writeback_i),
        .dc_wb_addr_i   (dc_wb_addr_i),
        .dc_wb_data_i   (dc_wb_data_i),
        .dc_rdy_o       (dc_rdy_o),
        .dc_data_o      (dc_data_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_ack_i      (mem_ack_i),
        .mem_rdata_i    (mem_rdata_i),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rsn_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rsn_i = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit           dc;
        logic [31:0]  addr;
        bit           wb;
        logic [31:0]  wb_addr;
        logic [127:0] wb_data;
        logic [127:0] rdata;
        int           delay;
        logic [31:0]  exp_addr;
        logic [31:0]  exp_wb_addr;
    } vec_t;

    vec_t vecs[5];

    task automatic mem_phase(input string tag, input bit we, input logic [31:0] addr,
                             input logic [127:0] wdata, input logic [127:0] rdata,
                             input int delay);
        for (int k = 1; k <= delay; k++) begin
            chk({tag, " req"}, mem_req_o, 1'b1);
            chk({tag, " we"}, mem_we_o, we);
            chk({tag, " addr"}, mem_addr_o, addr);
            chk({tag, " wdata"}, mem_wdata_o, wdata);
            chk({tag, " rdy early"}, ic_rdy_o | dc_rdy_o, 1'b0);
            if (k == delay) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rdata;
            end
            tick();
            mem_ack_i   = 1'b0;
            mem_rdata_i = {4{$urandom}};
        end
    endtask

    task automatic do_txn(input int idx, input vec_t v);
        string tag;
        tag            = $sformatf("vec%0d", idx);
        ic_miss_i      = !v.dc;
        dc_miss_i      = v.dc;
        ic_addr_i      = v.addr;
        dc_addr_i      = v.addr;
        dc_writeback_i = v.wb;
        dc_wb_addr_i   = v.wb_addr;
        dc_wb_data_i   = v.wb_data;
        tick();
        // Everything is latched at grant; later changes must not leak in.
        ic_addr_i      = $urandom;
        dc_addr_i      = $urandom;
        dc_wb_addr_i   = $urandom;
        dc_wb_data_i   = {4{$urandom}};
        dc_writeback_i = !v.wb;
        if (v.dc && v.wb) begin
            mem_phase({tag, " wb"}, 1'b1, v.exp_wb_addr, v.wb_data, '0, v.delay);
        end
        mem_phase({tag, " rd"}, 1'b0, v.exp_addr, '0, v.rdata, v.delay);
        chk({tag, " ic_rdy"}, ic_rdy_o, !v.dc);
        chk({tag, " dc_rdy"}, dc_rdy_o, v.dc);
        chk({tag, " data"}, v.dc ? dc_data_o : ic_data_o, v.rdata);
        chk({tag, " req in resp"}, mem_req_o, 1'b0);
        chk({tag, " busy in resp"}, busy_o, 1'b1);
        ic_miss_i = 1'b0;
        dc_miss_i = 1'b0;
        tick();
        chk({tag, " rdy single"}, ic_rdy_o | dc_rdy_o, 1'b0);
        chk({tag, " busy after"}, busy_o, 1'b0);
        chk({tag, " data held"}, v.dc ? dc_data_o : ic_data_o, v.rdata);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit           we;
        logic [31:0]  addr;
        logic [127:0] data;
    } op_t;

    op_t          ops[$];
    bit           m_resp;
    bit           m_who_dc;
    bit           m_last_dc;
    logic [127:0] m_ic_data;
    logic [127:0] m_dc_data;

    task automatic model_reset();
        ops.delete();
        m_resp    = 1'b0;
        m_who_dc  = 1'b0;
        m_last_dc = 1'b0;
        m_ic_data = '0;
        m_dc_data = '0;
    endtask

    // Advance one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit pick_dc;
        if (ops.size() != 0) begin
            if (mem_ack_i) begin
                if (!ops[0].we) begin
                    if (m_who_dc) m_dc_data = mem_rdata_i;
                    else          m_ic_data = mem_rdata_i;
                    m_resp = 1'b1;
                end
                void'(ops.pop_front());
            end
        end else if (m_resp) begin
            m_resp = 1'b0;
        end else if (ic_miss_i || dc_miss_i) begin
            pick_dc   = dc_miss_i && (!ic_miss_i || !m_last_dc);
            m_last_dc = pick_dc;
            m_who_dc  = pick_dc;
            if (pick_dc && dc_writeback_i) begin
                ops.push_back('{we: 1'b1, addr: dc_wb_addr_i & 32'hFFFF_FFF0,
                                data: dc_wb_data_i});
            end
            ops.push_back('{we: 1'b0, addr: (pick_dc ? dc_addr_i : ic_addr_i) & 32'hFFFF_FFF0,
                            data: '0});
        end
    endtask

    task automatic model_check();
        bit exp_req;
        exp_req = (ops.size() != 0);
        chk("rnd mem_req", mem_req_o, exp_req);
        if (exp_req) begin
            chk("rnd mem_we", mem_we_o, ops[0].we);
            chk("rnd mem_addr", mem_addr_o, ops[0].addr);
            chk("rnd mem_wdata", mem_wdata_o, ops[0].we ? ops[0].data : '0);
        end else begin
            chk("rnd mem_wdata idle", mem_wdata_o, '0);
        end
        chk("rnd ic_rdy", ic_rdy_o, m_resp && !m_who_dc);
        chk("rnd dc_rdy", dc_rdy_o, m_resp && m_who_dc);
        chk("rnd busy", busy_o, exp_req || m_resp);
        chk("rnd ic_data", ic_data_o, m_ic_data);
        chk("rnd dc_data", dc_data_o, m_dc_data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int cnt;

        vecs[0] = '{dc: 0, addr: 32'h0000_1234, wb: 0, wb_addr: 32'h0, wb_data: '0,
                    rdata: {16{8'hA5}}, delay: 3, exp_addr: 32'h0000_1230, exp_wb_addr: 32'h0};
        vecs[1] = '{dc: 1, addr: 32'h0000_0200, wb: 1, wb_addr: 32'h0000_08F0,
                    wb_data: {32{4'h1}}, rdata: {4{32'hCAFE_F00D}}, delay: 2,
                    exp_addr: 32'h0000_0200, exp_wb_addr: 32'h0000_08F0};
        vecs[2] = '{dc: 1, addr: 32'h0000_04FF, wb: 0, wb_addr: 32'h0000_5555,
                    wb_data: {4{32'h5A5A_5A5A}}, rdata: {4{32'h0123_4567}}, delay: 1,
                    exp_addr: 32'h0000_04F0, exp_wb_addr: 32'h0};
        vecs[3] = '{dc: 0, addr: 32'hFFFF_FFFF, wb: 1, wb_addr: 32'h0000_7770,
                    wb_data: {4{32'hDEAD_BEEF}}, rdata: {8{16'hBEEF}}, delay: 1,
                    exp_addr: 32'hFFFF_FFF0, exp_wb_addr: 32'h0};
        vecs[4] = '{dc: 1, addr: 32'h0001_0007, wb: 1, wb_addr: 32'hABCD_EF1F,
                    wb_data: {4{32'h1357_9BDF}}, rdata: {4{32'h2468_ACE0}}, delay: 4,
                    exp_addr: 32'h0001_0000, exp_wb_addr: 32'hABCD_EF10};

        ic_miss_i = 0; ic_addr_i = '0; dc_miss_i = 0; dc_addr_i = '0;
        dc_writeback_i = 0; dc_wb_addr_i = '0; dc_wb_data_i = '0;
        mem_ack_i = 0; mem_rdata_i = '0;
        do_reset();

        chk("reset busy", busy_o, 1'b0);
        chk("reset mem_req", mem_req_o, 1'b0);
        chk("reset mem_we", mem_we_o, 1'b0);
        chk("reset mem_addr", mem_addr_o, '0);
        chk("reset mem_wdata", mem_wdata_o, '0);
        chk("reset ic_rdy", ic_rdy_o, 1'b0);
        chk("reset dc_rdy", dc_rdy_o, 1'b0);
        chk("reset ic_data", ic_data_o, '0);
        chk("reset dc_data", dc_data_o, '0);

        for (int i = 0; i < 5; i++) begin
            do_txn(i, vecs[i]);
        end

        // Stray ack while idle.
        mem_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stray busy", busy_o, 1'b0);
            chk("stray req", mem_req_o, 1'b0);
            chk("stray rdy", ic_rdy_o | dc_rdy_o, 1'b0);
        end
        mem_ack_i = 1'b0;

        // Tie out of reset with both requesting continuously: DC, IC, DC, IC.
        do_reset();
        ic_miss_i = 1; ic_addr_i = 32'h100; dc_miss_i = 1; dc_addr_i = 32'h200;
        dc_writeback_i = 0; mem_ack_i = 1;
        cnt = 0;
        while (order.size() < 4 && cnt < 40) begin
            tick();
            cnt++;
            if (ic_rdy_o || dc_rdy_o) begin
                order.push_back(dc_rdy_o ? 1 : 0);
                chk("tie req low in resp", mem_req_o, 1'b0);
                chk("tie rdy exclusive", ic_rdy_o & dc_rdy_o, 1'b0);
            end
        end
        chk("tie pulse count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) begin
            chk($sformatf("tie grant %0d is dc", i), order[i], (i % 2 == 0) ? 1 : 0);
        end
        ic_miss_i = 0; dc_miss_i = 0; mem_ack_i = 0;
        repeat (3) tick();

        // Zero-wait memory latency: 2 cycles plain, 3 with writeback.
        mem_ack_i = 1; ic_miss_i = 1; ic_addr_i = 32'h40;
        cnt = 0;
        while (!ic_rdy_o && cnt < 10) begin
            tick();
            cnt++;
        end
        chk("zero-wait ic latency", cnt, 2);
        ic_miss_i = 0;
        tick();
        dc_miss_i = 1; dc_addr_i = 32'h80; dc_writeback_i = 1; dc_wb_addr_i = 32'h90;
        cnt = 0;
        while (!dc_rdy_o && cnt < 10) begin
            tick();
            cnt++;
            if (!dc_rdy_o && cnt == 1) chk("zero-wait wb we", mem_we_o, 1'b1);
        end
        chk("zero-wait dc wb latency", cnt, 3);
        dc_miss_i = 0; dc_writeback_i = 0; mem_ack_i = 0;
        repeat (2) tick();

        // Reset mid-RD: asynchronous clear, no ready, normal re-grant afterwards.
        ic_miss_i = 1; ic_addr_i = 32'h0000_3007;
        tick();
        chk("mid-rd req", mem_req_o, 1'b1);
        tick();
        #3 rsn_i = 1'b1;
        #1;
        chk("async rst req", mem_req_o, 1'b0);
        chk("async rst busy", busy_o, 1'b0);
        chk("async rst addr", mem_addr_o, '0);
        chk("async rst ic_data", ic_data_o, '0);
        @(posedge clk_i);
        #1;
        rsn_i = 1'b0;
        chk("rst no rdy", ic_rdy_o, 1'b0);
        tick();
        chk("regrant req", mem_req_o, 1'b1);
        chk("regrant addr", mem_addr_o, 32'h0000_3000);
        mem_ack_i = 1; mem_rdata_i = {4{32'h7777_0001}};
        tick();
        mem_ack_i = 0;
        chk("regrant rdy", ic_rdy_o, 1'b1);
        chk("regrant data", ic_data_o, {4{32'h7777_0001}});
        ic_miss_i = 0;
        tick();

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            if (ic_miss_i) begin
                if (m_resp && !m_who_dc) ic_miss_i = 0;
                else ic_addr_i = $urandom;
            end else if ($urandom_range(0, 3) == 0) begin
                ic_miss_i = 1;
                ic_addr_i = $urandom;
            end
            if (dc_miss_i) begin
                if (m_resp && m_who_dc) dc_miss_i = 0;
                else dc_addr_i = $urandom;
            end else if ($urandom_range(0, 3) == 0) begin
                dc_miss_i = 1;
                dc_addr_i = $urandom;
            end
            dc_writeback_i = $urandom_range(0, 1) == 1;
            dc_wb_addr_i   = $urandom;
            dc_wb_data_i   = {$urandom, $urandom, $urandom, $urandom};
            mem_ack_i      = $urandom_range(0, 2) == 0;
            mem_rdata_i    = {$urandom, $urandom, $urandom, $urandom};
            tick();
            model_step();
            model_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/segre_mem_arbiter.md
Name: segre_mem_arbiter

Overview:
- Sequences the single external memory port between the instruction-cache fill path and the data-cache miss path (MMU side of the memory pipeline).
- Serves one request at a time. A data-cache miss that needs a dirty-lane writeback is handled as a writeback followed by the refill read.
- Uses round-robin fairness when both caches miss in the same cycle.
- Returns the filled lane to the winning requester with a one-cycle ready pulse.

Parameters:
- ADDR_SIZE, 32, byte address width.
- LANE_SIZE, 128, cache lane width in bits (power of two, at least 8).
- OFFSET_BITS, $clog2(LANE_SIZE/8), lane byte-offset bits cleared on memory addresses.

Ports:
- clk_i  in  1  clock.
- rsn_i  in  1  reset.
- ic_miss_i  in  1  I-cache refill request; level, held until ic_rdy_o.
- ic_addr_i  in  ADDR_SIZE  I-cache miss address.
- ic_rdy_o  out  1  one-cycle pulse: ic_data_o valid.
- ic_data_o  out  LANE_SIZE  refill lane for I-cache.
- dc_miss_i  in  1  D-cache refill request; level, held until dc_rdy_o.
- dc_addr_i  in  ADDR_SIZE  D-cache miss address.
- dc_writeback_i  in  1  victim lane is dirty; sampled with grant.
- dc_wb_addr_i  in  ADDR_SIZE  victim lane address.
- dc_wb_data_i  in  LANE_SIZE  victim lane data.
- dc_rdy_o  out  1  one-cycle pulse: dc_data_o valid.
- dc_data_o  out  LANE_SIZE  refill lane for D-cache.
- mem_req_o  out  1  memory request valid.
- mem_we_o  out  1  1 = write lane, 0 = read lane.
- mem_addr_o  out  ADDR_SIZE  lane-aligned memory address.
- mem_wdata_o  out  LANE_SIZE  write data.
- mem_ack_i  in  1  memory accepts/completes current request; mem_rdata_i valid on reads.
- mem_rdata_i  in  LANE_SIZE  read data.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Interface (already decided): one clock (clk_i); reset rsn_i is asynchronous and active-high.
- Reset: all outputs 0; FSM = IDLE; last_grant = IC, so the D-cache wins the first tie.
- All outputs are registered.
- FSM states: IDLE, WB, RD, RESP.
- IDLE transitions:
  - No requests: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the one not equal to last_grant.
  - On grant: latch requester id and lane-aligned addresses (low OFFSET_BITS cleared); update last_grant.
  - If D-cache granted and dc_writeback_i=1: latch dc_wb_data_i, go to WB. Otherwise go to RD.
- WB: mem_req_o=1, mem_we_o=1, mem_addr_o = latched victim address, mem_wdata_o = latched victim data. Held stable until mem_ack_i; on ack go to RD.
- RD: mem_req_o=1, mem_we_o=0, mem_addr_o = latched miss address. Held until mem_ack_i; on ack capture mem_rdata_i into the granted requester's data register and go to RESP.
- RESP: pulse the granted requester's rdy_o for exactly one cycle, then go to IDLE. No new grant is made in the RESP cycle, so a requester dropping its request after rdy is never re-granted.
- mem_req_o is deasserted in the cycle after the ack. There is no back-to-back request without passing RESP/IDLE (WB to RD excepted, where mem_req_o stays high and mem_we_o drops).
- Latency: request sampled in IDLE at cycle 0 → mem_req_o at cycle 1 → ack at cycle n (n ≥ 1) → rdy at n+1. Minimum is 2 cycles without writeback, 3 with.
- mem_wdata_o is 0 outside WB.
- ic_data_o and dc_data_o hold their last captured lane until the next capture for that requester.
- mem_ack_i outside WB/RD is ignored.
- A requester dropping its miss while granted is a protocol violation; the transaction still completes and rdy still pulses.
- Addresses and data are sampled only at grant. Later input changes do not affect the ongoing transaction.
- Reset asserted mid-transaction aborts immediately to IDLE; no rdy pulse; memory-side cleanup is the system's responsibility.

Test Plan:
- I-cache only: ic_miss_i=1, ic_addr_i=0x0000_1234, ack after 3 cycles with rdata=0xA5…A5 → mem_addr_o=0x0000_1230, mem_we_o=0; ic_rdy_o pulses once; ic_data_o=0xA5…A5; busy_o falls the cycle after the pulse.
- D-cache with writeback: dc_miss_i=1, dc_addr_i=0x200, dc_writeback_i=1, dc_wb_addr_i=0x8F0, wb data 0x1111… → write to 0x8F0 with data 0x1111…, then read of 0x200; dc_rdy_o pulses only after the read ack.
- Simultaneous misses out of reset: both requests held → D-cache served first, then I-cache; with both continuously requesting, grants alternate DC, IC, DC, IC.
- Zero-wait memory: mem_ack_i tied 1 → rdy pulses 2 cycles after the request is sampled (3 with writeback); mem_req_o never stays high across a RESP.
- Reset mid-RD: assert rsn_i while mem_req_o=1 → all outputs 0 asynchronously; no rdy pulse; after release a held ic_miss_i is re-granted normally.
- Stray ack: mem_ack_i=1 in IDLE with no requests → no state change; rdy outputs stay 0.
